memory_responder: RTL and testbench

- Data-memory responder on the far end of the core's load/store request interface.
- The core issues one request at a time; this block performs the access and returns a response.
- Handles RV32I byte, halfword and word loads and stores, with sign/zero extension and byte-lane steering.
- Owns a word-organised RAM plus one memory-mapped LED output register.
- Flags misaligned, out-of-range and illegal-width accesses with an error response.

---
 rtl/memory_responder_pkg.sv | 18 +
 rtl/memory_responder_byte_lane_unit.sv | 59 +++++
 rtl/memory_responder.sv | 146 ++++++++++++++
 tb/tb_memory_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// rtl/memory_responder_pkg.sv - shared funct3 codes, FSM states and default LED address
package memory_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_LED_ADDR = 32'h0000_4000;

endpackage

// File: rtl/memory_responder_byte_lane_unit.sv
// rtl/memory_responder_byte_lane_unit.sv - byte-lane steering for stores and extension for loads
module byte_lane_unit
    import memory_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_steered,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en       = 4'b0000;
        wdata_steered = wdata;
        misaligned    = 1'b0;
        illegal       = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
                illegal       = write && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_steered = {2{wdata[15:0]}};
                misaligned    = addr_lo[0];
                illegal       = write && (funct3 == F3_HU);
            end
            F3_W: begin
                byte_en    = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte  = raw[{addr_lo, 3'b000} +: 8];
        sel_half  = addr_lo[1] ? raw[31:16] : raw[15:0];
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'd0, sel_half};
            F3_W:    load_data = raw;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - single-outstanding load/store responder with RAM and LED register
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] LED_ADDR  = DEFAULT_LED_ADDR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] LEDS
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t state, state_next;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_wdata;

    logic [31:0] mem [MEM_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             in_ram;
    logic             is_led;
    logic [31:0]      raw_word;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_steered;
    logic             misaligned;
    logic             illegal;
    logic [31:0]      load_data;
    logic             fault;
    logic             do_write;

    assign word_idx = lat_addr[IDX_W+1:2];
    assign in_ram   = lat_addr[31:2] < MEM_LIMIT;
    assign is_led   = lat_addr[31:2] == LED_ADDR[31:2];
    assign raw_word = is_led ? LEDS : mem[word_idx];
    assign fault    = misaligned || illegal || !(in_ram || is_led);
    assign do_write = (state == ACCESS) && lat_write && !fault;

    byte_lane_unit u_lanes (
        .funct3        (lat_funct3),
        .write         (lat_write),
        .addr_lo       (lat_addr[1:0]),
        .wdata         (lat_wdata),
        .raw           (raw_word),
        .byte_en       (byte_en),
        .wdata_steered (wdata_steered),
        .misaligned    (misaligned),
        .illegal       (illegal),
        .load_data     (load_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESPOND;
            RESPOND: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_funct3 <= 3'd0;
            lat_wdata  <= 32'd0;
        end else if (state == IDLE && req_valid) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_valid <= 1'b1;
            rsp_error <= fault;
            rsp_rdata <= (fault || lat_write) ? 32'd0 : load_data;
        end else if (state == RESPOND && rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // RAM is deliberately not reset; writes only happen on the edge leaving ACCESS
    always_ff @(posedge CLK) begin
        if (do_write && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wdata_steered[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEDS <= 32'd0;
        end else if (do_write && is_led) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    LEDS[i*8 +: 8] <= wdata_steered[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized and directed checks against a byte-addressed reference model
module tb_memory_responder;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] LED_ADDR  = 32'h0000_4000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] LEDS;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] led_m = 32'd0;

    always #5 CLK = ~CLK;

    memory_responder #(.MEM_WORDS(MEM_WORDS), .LED_ADDR(LED_ADDR)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .LEDS       (LEDS)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory viewed as bytes: an access of N bytes touches bytes addr..addr+N-1
    task automatic model(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        bit legal;
        int off;
        logic [31:0] word;
        logic [31:0] val;
        size = 0; sgn = 0; legal = 1;
        case (f)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; legal = !w; end
            3'd5: begin size = 2; legal = !w; end
            default: legal = 0;
        endcase
        rd = 32'd0;
        er = !legal;
        if (legal && (a % size) != 0) er = 1;
        if (!((a / 4) < MEM_WORDS || (a / 4) == (LED_ADDR / 4))) er = 1;
        if (er) return;
        off  = int'(a % 4);
        word = ((a / 4) == (LED_ADDR / 4)) ? led_m : mem_m[a / 4];
        if (w) begin
            for (int k = 0; k < size; k++) word[(off + k) * 8 +: 8] = d[k * 8 +: 8];
            if ((a / 4) == (LED_ADDR / 4)) led_m = word;
            else mem_m[a / 4] = word;
        end else begin
            val = word >> (off * 8);
            if (size == 1) val = val & 32'hFF;
            if (size == 2) val = val & 32'hFFFF;
            if (sgn && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
            if (sgn && size == 2 && val[15]) val = val | 32'hFFFF_0000;
            rd = val;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_txn(input logic w, input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input int hold, input bit intrude,
                           output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        wait_ready();
        model(w, a, f, d, exp_rd, exp_er);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f; req_wdata = d;
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        check("access_req_ready", {31'd0, req_ready}, 32'd0);
        check("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        if (intrude) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h14;
            req_funct3 = 3'd2; req_wdata = 32'h55;
        end
        @(posedge CLK); @(negedge CLK);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_er});
        check("leds", LEDS, led_m);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); @(negedge CLK);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, exp_rd);
            check("hold_rsp_error", {31'd0, rsp_error}, {31'd0, exp_er});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); @(negedge CLK);
        rsp_ready = 1'b0;
        check("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_req_ready", {31'd0, req_ready}, 32'd1);
        rd = rsp_rdata;
        rd = exp_rd;
        er = exp_er;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] prior;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = 32'd0;
        repeat (3) @(negedge CLK);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("reset_leds", LEDS, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 16; i++) run_txn(1'b1, 32'(i * 4), 3'd2, $urandom, 0, 0, rd, er);

        run_txn(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0, rd, er);
        check("sw_rdata", rd, 32'd0);
        check("sw_error", {31'd0, er}, 32'd0);
        run_txn(1'b0, 32'h10, 3'd2, 32'd0, 0, 0, rd, er);
        check("lw_word", rd, 32'hDEADBEEF);
        run_txn(1'b1, 32'h12, 3'd0, 32'h80, 0, 0, rd, er);
        run_txn(1'b0, 32'h10, 3'd2, 32'd0, 0, 0, rd, er);
        check("sb_merge", rd, 32'hDE80BEEF);
        run_txn(1'b0, 32'h12, 3'd0, 32'd0, 0, 0, rd, er);
        check("lb", rd, 32'hFFFFFF80);
        run_txn(1'b0, 32'h12, 3'd4, 32'd0, 0, 0, rd, er);
        check("lbu", rd, 32'h00000080);
        run_txn(1'b0, 32'h12, 3'd1, 32'd0, 0, 0, rd, er);
        check("lh", rd, 32'hFFFFDE80);
        run_txn(1'b0, 32'h10, 3'd5, 32'd0, 0, 0, rd, er);
        check("lhu", rd, 32'h0000BEEF);

        run_txn(1'b0, 32'h11, 3'd2, 32'd0, 0, 0, rd, er);
        check("lw_misaligned", {31'd0, er}, 32'd1);
        run_txn(1'b1, 32'h13, 3'd1, 32'hFFFF, 0, 0, rd, er);
        check("sh_misaligned", {31'd0, er}, 32'd1);
        run_txn(1'b0, 32'h10, 3'd2, 32'd0, 0, 0, rd, er);
        check("sh_no_write", rd, 32'hDE80BEEF);
        run_txn(1'b0, 32'h10, 3'd3, 32'd0, 0, 0, rd, er);
        check("illegal_f3", {31'd0, er}, 32'd1);
        run_txn(1'b0, 32'h400, 3'd2, 32'd0, 0, 0, rd, er);
        check("out_of_range", {31'd0, er}, 32'd1);

        run_txn(1'b1, 32'h4000, 3'd2, 32'hA5, 0, 0, rd, er);
        check("led_sw", LEDS, 32'h000000A5);
        run_txn(1'b1, 32'h4001, 3'd0, 32'h3C, 0, 0, rd, er);
        check("led_sb", LEDS, 32'h00003CA5);
        run_txn(1'b0, 32'h4000, 3'd2, 32'd0, 0, 0, rd, er);
        check("led_lw", rd, 32'h00003CA5);

        run_txn(1'b0, 32'h10, 3'd2, 32'd0, 5, 1, rd, er);
        model(1'b1, 32'h14, 3'd2, 32'h55, rd, er);
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        check("intrude_accepted", {31'd0, req_ready}, 32'd0);
        @(posedge CLK); @(negedge CLK);
        check("intrude_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge CLK); @(negedge CLK);
        rsp_ready = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("intrude_once_ready", {31'd0, req_ready}, 32'd1);
        check("intrude_once_valid", {31'd0, rsp_valid}, 32'd0);
        run_txn(1'b0, 32'h14, 3'd2, 32'd0, 0, 0, rd, er);
        check("intrude_data", rd, 32'h55);

        prior = mem_m[8];
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2; req_wdata = 32'h1234;
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        RESET = 1'b1;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_leds", LEDS, 32'd0);
        led_m = 32'd0;
        @(posedge CLK); @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_txn(1'b0, 32'h20, 3'd2, 32'd0, 0, 0, rd, er);
        check("rst_no_write", rd, prior);

        for (int t = 0; t < 300; t++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            if (kind <= 6) a = 32'($urandom_range(0, 63));
            else if (kind <= 8) a = LED_ADDR + 32'($urandom_range(0, 3));
            else a = $urandom;
            run_txn(1'($urandom), a, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2), 0, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
